traffic_phase_sequencer: RTL and testbench
==========================================

// Module: traffic_phase_sequencer
// PURPOSE
//  Parametrised 4-approach junction controller (mains M1/M2, main turn MT, side S).
//  Runs the fixed phase cycle MG->M2Y->TG->MY->AR1->SG->SY->AR2->MG:
//   - phase durations are parameters;
//   - the cycle advances from an internal second-tick prescaler;
//   - leaving main-green is demand-gated;
//   - pedestrian request/ack handshake;
//   - all-red clearance phases;
//   - night flash mode.
//  Sits between the junction sensor interface and the lamp drivers.
// PARAMETERS
//  TICK_DIV  1  clk cycles per tick (>=1)
//  CNT_W     8  phase counter width; all durations < 2**CNT_W
//  DUR_MG    7  ticks, M1+M2 green (minimum; extended while no demand)
//  DUR_M2Y   2  ticks, M2 yellow, M1 green
//  DUR_TG    5  ticks, M1+MT green
//  DUR_MY    2  ticks, M1+MT yellow
//  DUR_AR    1  ticks, each all-red clearance (AR1, AR2)
//  DUR_SG    3  ticks, side green + ped walk
//  DUR_SY    2  ticks, side yellow
// PORTS
//  clk         in   1      clock
//  rst         in   1      reset, asynchronous, active-high
//  side_det    in   1      side-road vehicle present (level)
//  turn_det    in   1      turn-lane vehicle present (level)
//  ped_req     in   1      pedestrian button, 1-cycle pulse
//  flash_mode  in   1      night flash request (level)
//  ped_ack     out  1      1-cycle pulse: pending ped request served
//  ped_walk    out  1      walk lamp
//  light_M1    out  3      {R,Y,G}; R=100, Y=010, G=001, dark=000
//  light_M2    out  3      same encoding
//  light_MT    out  3      same encoding
//  light_S     out  3      same encoding
//  phase       out  4      current phase code (traffic_pkg::phase_t)
// BEHAVIOUR
//  Reset values (all registered):
//   - state AR2, phase count 0, prescaler 0, blink 0;
//   - ped_pending 0, ped_ack 0, ped_walk 0;
//   - all four lights 100.
//  Tick generation:
//   - tick=1 in the cycle the prescaler equals TICK_DIV-1, then the prescaler wraps to 0;
//   - with TICK_DIV=1, tick is 1 every cycle.
//  Phase timing:
//   - the count advances only on tick;
//   - a phase ends on the tick where count==DUR-1, with count<=0 and the next state loaded the same edge;
//   - a phase of duration D therefore lasts exactly D ticks;
//   - a DUR of 0 is treated as 1.
//  MG exit:
//   - at the end of the minimum time, leave only if demand = side_det|turn_det|ped_pending;
//   - otherwise stay in MG with count saturated at DUR_MG-1 and re-check every tick.
//  Pedestrian handshake:
//   - ped_req sets ped_pending;
//   - on the edge entering SG: ped_pending clears and ped_ack pulses for 1 cycle (only if it was set);
//   - ped_req in that same cycle wins, so pending stays 1 and is served next cycle round;
//   - ped_walk=1 throughout SG, 0 elsewhere.
//  Lights per phase (M1, M2, MT, S):
//   - MG:  G, G, R, R
//   - M2Y: G, Y, R, R
//   - TG:  G, R, G, R
//   - MY:  Y, R, Y, R
//   - AR1/AR2: R, R, R, R
//   - SG:  R, R, R, G
//   - SY:  R, R, R, Y
//  Lights are a pure decode of the state/blink registers, with no added latency.
//  Flash mode:
//   - if flash_mode=1 when AR2 ends, next state is FLASH instead of MG; other phases are never cut short;
//   - in FLASH, blink toggles every tick;
//     - blink=1: M1/M2 = 010, MT/S = 100;
//     - blink=0: all lights dark (000).
//   - in FLASH, flash_mode=0 sampled on a tick -> AR2 with count 0, then the normal cycle.
//   - ped requests latch during FLASH but are not served there.
//  Safety invariant: no two of {M2|MT, S} are non-red in the same cycle, and no conflicting greens.
//  An illegal state code decodes to all-red and goes to AR2 on the next clk.
//  rst mid-phase: immediate all-red, and pending requests are lost.
// STRUCTURE
//  traffic_pkg holds:
//   - phase_t enum: MG=0, M2Y=1, TG=2, MY=3, AR1=4, SG=5, SY=6, AR2=7, FLASH=8;
//   - lamp constants LAMP_R/LAMP_Y/LAMP_G/LAMP_OFF.
//  Sub-module tick_prescaler #(TICK_DIV): clk, rst -> tick.
//  FSM, phase counter, ped latch and light decode stay in this module.
// TESTING (TICK_DIV=1, defaults)
//  1. Reset release, side_det=1 held:
//     - AR2 for 1 cycle, then MG 7, M2Y 2, TG 5, MY 2, AR1 1, SG 3, SY 2, AR2 1;
//     - loop period 23 cycles.
//  2. No demand: MG persists for 50 cycles.
//     - Pulse ped_req: MG exits on the next tick.
//     - ped_ack is a 1-cycle pulse on SG entry, and ped_walk is high for exactly 3 cycles.
//  3. ped_req in the SG-entry cycle:
//     - ped_ack fires;
//     - ped_pending stays 1;
//     - the next MG exits after its minimum time with no detectors set.
//  4. flash_mode=1 raised mid-TG:
//     - the cycle completes through AR2, then FLASH;
//     - M1 alternates 010/000 each cycle;
//     - flash_mode=0 -> AR2 for 1 cycle, then MG.
//  5. TICK_DIV=4, DUR_MG=3:
//     - MG lasts 12 clk cycles;
//     - rst asserted mid-SG forces all lights 100 asynchronously.
//  6. Random detectors/ped/flash for 10k cycles:
//     - an assertion checks the safety invariant;
//     - an assertion checks one-hot-or-dark on every light.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: phase codes, lamp encodings and duration helper for the junction sequencer
package traffic_pkg;
  typedef enum logic [3:0] {
    MG = 4'd0, M2Y = 4'd1, TG = 4'd2, MY = 4'd3, AR1 = 4'd4,
    SG = 4'd5, SY = 4'd6, AR2 = 4'd7, FLASH = 4'd8
  } phase_t;
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;
  // final count of a phase; a zero duration behaves as one tick
  function automatic int last_of(int d);
    return d > 1 ? d - 1 : 0;
  endfunction
endpackage

// File: rtl/traffic_phase_sequencer_tick_prescaler.sv
// tick_prescaler: one-cycle tick every TICK_DIV clocks
module tick_prescaler #(parameter int TICK_DIV = 1) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(TICK_DIV - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: 4-approach junction phase FSM with demand-gated main green,
// pedestrian handshake, all-red clearances and night flash
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = 1,
  parameter int CNT_W = 8,
  parameter int DUR_MG = 7,
  parameter int DUR_M2Y = 2,
  parameter int DUR_TG = 5,
  parameter int DUR_MY = 2,
  parameter int DUR_AR = 1,
  parameter int DUR_SG = 3,
  parameter int DUR_SY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_det,
  input  logic       turn_det,
  input  logic       ped_req,
  input  logic       flash_mode,
  output logic       ped_ack,
  output logic       ped_walk,
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S,
  output logic [3:0] phase
);
  phase_t state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, last_cnt;
  logic tick, last, blink, ped_pending, demand, sg_in;
  logic [11:0] lamps;
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));
  always_comb begin
    last_cnt = '0;
    case (state)
      MG:       last_cnt = CNT_W'(last_of(DUR_MG));
      M2Y:      last_cnt = CNT_W'(last_of(DUR_M2Y));
      TG:       last_cnt = CNT_W'(last_of(DUR_TG));
      MY:       last_cnt = CNT_W'(last_of(DUR_MY));
      AR1, AR2: last_cnt = CNT_W'(last_of(DUR_AR));
      SG:       last_cnt = CNT_W'(last_of(DUR_SG));
      SY:       last_cnt = CNT_W'(last_of(DUR_SY));
      default:  last_cnt = '0;
    endcase
  end
  assign demand = side_det | turn_det | ped_pending;
  assign last = tick && cnt == last_cnt;
  always_comb begin
    nxt = state;
    case (state)
      MG:      nxt = last && demand ? M2Y : MG;
      M2Y:     nxt = last ? TG : M2Y;
      TG:      nxt = last ? MY : TG;
      MY:      nxt = last ? AR1 : MY;
      AR1:     nxt = last ? SG : AR1;
      SG:      nxt = last ? SY : SG;
      SY:      nxt = last ? AR2 : SY;
      AR2:     nxt = last ? (flash_mode ? FLASH : MG) : AR2;
      FLASH:   nxt = tick && !flash_mode ? AR2 : FLASH;
      default: nxt = AR2;
    endcase
  end
  // a held MG keeps its count parked at the final value so demand is re-checked every tick
  assign cnt_nxt = (nxt != state || state == FLASH) ? '0 : (tick && !last) ? cnt + CNT_W'(1) : cnt;
  assign sg_in = state == AR1 && nxt == SG;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= AR2;
      cnt <= '0;
      blink <= 1'b0;
      ped_pending <= 1'b0;
      ped_ack <= 1'b0;
      ped_walk <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      blink <= state == FLASH && nxt == FLASH && (tick ? ~blink : blink);
      ped_pending <= ped_req | (ped_pending & ~sg_in);
      ped_ack <= sg_in & ped_pending;
      ped_walk <= nxt == SG;
    end
  always_comb begin
    lamps = {4{LAMP_R}};
    case (state)
      MG:    lamps = {LAMP_G, LAMP_G, LAMP_R, LAMP_R};
      M2Y:   lamps = {LAMP_G, LAMP_Y, LAMP_R, LAMP_R};
      TG:    lamps = {LAMP_G, LAMP_R, LAMP_G, LAMP_R};
      MY:    lamps = {LAMP_Y, LAMP_R, LAMP_Y, LAMP_R};
      SG:    lamps = {LAMP_R, LAMP_R, LAMP_R, LAMP_G};
      SY:    lamps = {LAMP_R, LAMP_R, LAMP_R, LAMP_Y};
      FLASH: lamps = blink ? {LAMP_Y, LAMP_Y, LAMP_R, LAMP_R} : {4{LAMP_OFF}};
      default: lamps = {4{LAMP_R}};
    endcase
  end
  assign {light_M1, light_M2, light_MT, light_S} = lamps;
  assign phase = state;
endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// tb_traffic_phase_sequencer: two sequencer instances (tick every clk / every 4 clks)
// scoreboarded against a tick-counting phase model
module tb_traffic_phase_sequencer;
  typedef struct {int ph; int el; int pre; bit pend; bit blink; bit ack; bit walk;} mdl_t;
  typedef struct {logic [3:0] ph; logic [11:0] lm; logic ack; logic walk;} obs_t;
  typedef struct {obs_t a; obs_t b;} exp_t;
  logic clk = 0, rst = 1, side_det = 0, turn_det = 0, ped_req = 0, flash_mode = 0;
  logic ack_a, walk_a, ack_b, walk_b;
  logic [11:0] la, lb;
  logic [3:0] ph_a, ph_b;
  int checks = 0, errors = 0;
  exp_t q[$];
  mdl_t ma = '{7, 0, 0, 0, 0, 0, 0}, mb = '{7, 0, 0, 0, 0, 0, 0};
  traffic_phase_sequencer dut (
    .clk(clk), .rst(rst), .side_det(side_det), .turn_det(turn_det), .ped_req(ped_req),
    .flash_mode(flash_mode), .ped_ack(ack_a), .ped_walk(walk_a), .light_M1(la[11:9]),
    .light_M2(la[8:6]), .light_MT(la[5:3]), .light_S(la[2:0]), .phase(ph_a));
  traffic_phase_sequencer #(.TICK_DIV(4), .DUR_MG(3)) dut4 (
    .clk(clk), .rst(rst), .side_det(side_det), .turn_det(turn_det), .ped_req(ped_req),
    .flash_mode(flash_mode), .ped_ack(ack_b), .ped_walk(walk_b), .light_M1(lb[11:9]),
    .light_M2(lb[8:6]), .light_MT(lb[5:3]), .light_S(lb[2:0]), .phase(ph_b));
  always #5 clk = ~clk;
  function automatic int dur(int p, int dmg);
    int r;
    case (p)
      0: r = dmg;
      1: r = 2;
      2: r = 5;
      3: r = 2;
      5: r = 3;
      6: r = 2;
      default: r = 1;
    endcase
    return r < 1 ? 1 : r;
  endfunction
  // el counts completed ticks in the current phase
  function automatic mdl_t step(mdl_t m, bit r, bit sd, bit td, bit pr, bit fm, int div, int dmg);
    mdl_t n;
    bit tick, sg_in;
    n = m;
    sg_in = 0;
    if (r) begin
      n = '{7, 0, 0, 0, 0, 0, 0};
      return n;
    end
    tick = m.pre == div - 1;
    n.pre = tick ? 0 : m.pre + 1;
    if (tick) begin
      if (m.ph == 8) begin
        if (fm) n.blink = !m.blink;
        else begin n.ph = 7; n.el = 0; n.blink = 0; end
      end else begin
        n.el = m.el + 1;
        if (n.el >= dur(m.ph, dmg)) begin
          if (m.ph == 0 && !(sd | td | m.pend)) n.el = dur(0, dmg);
          else begin
            n.el = 0;
            n.ph = m.ph == 7 ? (fm ? 8 : 0) : m.ph + 1;
            sg_in = n.ph == 5;
          end
        end
      end
    end
    n.ack = sg_in & m.pend;
    n.pend = pr | (m.pend & !sg_in);
    n.walk = n.ph == 5;
    return n;
  endfunction
  function automatic logic [11:0] lamps(mdl_t m);
    case (m.ph)
      0: return {3'b001, 3'b001, 3'b100, 3'b100};
      1: return {3'b001, 3'b010, 3'b100, 3'b100};
      2: return {3'b001, 3'b100, 3'b001, 3'b100};
      3: return {3'b010, 3'b100, 3'b010, 3'b100};
      5: return {3'b100, 3'b100, 3'b100, 3'b001};
      6: return {3'b100, 3'b100, 3'b100, 3'b010};
      8: return m.blink ? {3'b010, 3'b010, 3'b100, 3'b100} : 12'h000;
      default: return {4{3'b100}};
    endcase
  endfunction
  function automatic obs_t obs(mdl_t m);
    obs_t o;
    o.ph = 4'(m.ph);
    o.lm = lamps(m);
    o.ack = m.ack;
    o.walk = m.walk;
    return o;
  endfunction
  task automatic cmp(string n, obs_t e, logic [3:0] p, logic [11:0] l, logic a, logic w);
    checks += 4;
    if (p !== e.ph) begin errors++; $display("FAIL phase_%s got %0d want %0d", n, p, e.ph); end
    if (l !== e.lm) begin errors++; $display("FAIL lights_%s got %o want %o (phase %0d)", n, l, e.lm, e.ph); end
    if (a !== e.ack) begin errors++; $display("FAIL ped_ack_%s got %b want %b", n, a, e.ack); end
    if (w !== e.walk) begin errors++; $display("FAIL ped_walk_%s got %b want %b", n, w, e.walk); end
  endtask
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      cmp("a", e.a, ph_a, la, ack_a, walk_a);
      cmp("b", e.b, ph_b, lb, ack_b, walk_b);
    end
  end
  function automatic bit nr(logic [2:0] x);
    return x[1] | x[0];
  endfunction
  task automatic chk_safe(string n, logic [11:0] l);
    checks++;
    assert (!((nr(l[8:6]) | nr(l[5:3])) & nr(l[2:0])) && !(l[6] & l[3]) && !(l[6] & l[0]) &&
            !(l[3] & l[0]) && $onehot0(l[11:9]) && $onehot0(l[8:6]) && $onehot0(l[5:3]) && $onehot0(l[2:0]))
    else begin errors++; $display("FAIL safety_%s lamps %o not safe/one-hot-or-dark", n, l); end
  endtask
  always @(negedge clk) if (!rst) begin
    chk_safe("a", la);
    chk_safe("b", lb);
  end
  task automatic cyc(bit r, bit sd, bit td, bit pr, bit fm);
    exp_t e;
    @(negedge clk);
    side_det = sd; turn_det = td; ped_req = pr; flash_mode = fm;
    ma = step(ma, r, sd, td, pr, fm, 1, 7);
    mb = step(mb, r, sd, td, pr, fm, 4, 3);
    e.a = obs(ma);
    e.b = obs(mb);
    q.push_back(e);
    if (r && !rst) begin
      #2 rst = 1;
      #1 checks += 2;
      if (la !== 12'o4444) begin errors++; $display("FAIL async_rst_a got %o want 4444", la); end
      if (lb !== 12'o4444) begin errors++; $display("FAIL async_rst_b got %o want 4444", lb); end
    end else if (!r) rst = 0;
  endtask
  initial begin
    bit fm = 0;
    repeat (2) cyc(1, 0, 0, 0, 0);
    repeat (60) cyc(0, 1, 0, 0, 0);
    repeat (50) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    repeat (30) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 100 && ma.ph != 4; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    repeat (40) cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 100 && ma.ph != 2; i++) cyc(0, 0, 1, 0, 0);
    repeat (40) cyc(0, 0, 1, 0, 1);
    repeat (30) cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 300 && mb.ph != 5; i++) cyc(0, 1, 0, 0, 0);
    repeat (2) cyc(1, 1, 0, 0, 0);
    repeat (10) cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 299) == 0) fm = !fm;
      cyc($urandom_range(0, 1999) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 15) == 0, fm);
    end
    @(posedge clk);
    #2 $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
